// File: rtl/denormalization_module.sv
// rtl/denormalization_module.sv - multi-cycle mantissa right-shifter producing guard/round/sticky bits
module denormalization_module #(
    parameter int MANT_W = 8,
    parameter int STEP   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [MANT_W-1:0]        in_vector,
    input  logic [$clog2(MANT_W):0]  in_shift,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [MANT_W-1:0]        out_vector,
    output logic                     out_guard,
    output logic                     out_round,
    output logic                     out_sticky
);

    localparam int W    = MANT_W + 2;
    localparam int SH_W = $clog2(MANT_W) + 1;
    localparam int RW   = $clog2(W + 1);
    localparam int CW   = ((SH_W > RW) ? SH_W : RW) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   work_q, work_d;
    logic           sticky_q, sticky_d;
    logic [RW-1:0]  rem_q, rem_d;
    logic [W-1:0]   res_q, res_d;
    logic           res_sticky_q, res_sticky_d;

    logic [CW-1:0]  shift_ext;
    logic [RW-1:0]  clamp_amt;
    logic [RW-1:0]  step_k;
    logic [RW-1:0]  rem_next;
    logic [W-1:0]   shifted;
    logic           lost;

    always_comb begin
        shift_ext = CW'(in_shift);
        clamp_amt = (shift_ext > CW'(W)) ? RW'(W) : RW'(shift_ext);
        step_k    = (rem_q < RW'(STEP)) ? rem_q : RW'(STEP);
        rem_next  = rem_q - step_k;
        shifted   = work_q >> step_k;
        // Bits falling off the LSB end this step all fold into sticky.
        lost      = |(work_q & ~({W{1'b1}} << step_k));
    end

    always_comb begin
        state_d      = state_q;
        work_d       = work_q;
        sticky_d     = sticky_q;
        rem_d        = rem_q;
        res_d        = res_q;
        res_sticky_d = res_sticky_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d   = {in_vector, 2'b00};
                    sticky_d = 1'b0;
                    rem_d    = clamp_amt;
                    if (clamp_amt == '0) begin
                        state_d      = DONE;
                        res_d        = {in_vector, 2'b00};
                        res_sticky_d = 1'b0;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                work_d   = shifted;
                sticky_d = sticky_q | lost;
                rem_d    = rem_next;
                if (rem_next == '0) begin
                    state_d      = DONE;
                    res_d        = shifted;
                    res_sticky_d = sticky_q | lost;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            work_q       <= '0;
            sticky_q     <= 1'b0;
            rem_q        <= '0;
            res_q        <= '0;
            res_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            work_q       <= work_d;
            sticky_q     <= sticky_d;
            rem_q        <= rem_d;
            res_q        <= res_d;
            res_sticky_q <= res_sticky_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign out_vector = res_q[W-1:2];
    assign out_guard  = res_q[1];
    assign out_round  = res_q[0];
    assign out_sticky = res_sticky_q;

endmodule

// File: tb/tb_denormalization_module.sv
// tb/tb_denormalization_module.sv - directed bench for denormalization_module (STEP=1 and STEP=4)
module tb_denormalization_module;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sel = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_vector = '0;
    logic [3:0] in_shift = '0;
    logic       out_ready = 1'b0;

    logic       rdy1, val1, g1, r1, s1;
    logic [7:0] vec1;
    logic       rdy4, val4, g4, r4, s4;
    logic [7:0] vec4;

    logic       o_ready, o_valid, o_g, o_r, o_s;
    logic [7:0] o_vec;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [7:0] prev_vec [2];

    always #5 clk = ~clk;

    denormalization_module #(.MANT_W(8), .STEP(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid & ~sel), .in_ready(rdy1),
        .in_vector(in_vector), .in_shift(in_shift), .out_valid(val1),
        .out_ready(out_ready), .out_vector(vec1), .out_guard(g1),
        .out_round(r1), .out_sticky(s1)
    );

    denormalization_module #(.MANT_W(8), .STEP(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid & sel), .in_ready(rdy4),
        .in_vector(in_vector), .in_shift(in_shift), .out_valid(val4),
        .out_ready(out_ready), .out_vector(vec4), .out_guard(g4),
        .out_round(r4), .out_sticky(s4)
    );

    assign o_ready = sel ? rdy4 : rdy1;
    assign o_valid = sel ? val4 : val1;
    assign o_vec   = sel ? vec4 : vec1;
    assign o_g     = sel ? g4 : g1;
    assign o_r     = sel ? r4 : r1;
    assign o_s     = sel ? s4 : s1;

    task automatic do_op(input logic use4, input logic [7:0] v, input logic [3:0] sh,
                         input int exp_lat, input logic [7:0] ev, input logic eg,
                         input logic er, input logic es, input string name);
        int lat;
        @(negedge clk);
        sel = use4;
        total_cnt++;
        if (o_ready !== 1'b1) $display("FAIL %s ready_before: got %b expected 1", name, o_ready);
        else pass_cnt++;
        in_valid = 1'b1; in_vector = v; in_shift = sh;
        @(posedge clk); #1 in_valid = 1'b0;
        lat = 0;
        @(negedge clk);
        if (!o_valid) begin
            total_cnt++;
            if (o_vec !== prev_vec[use4]) $display("FAIL %s hold_in_shift: got %h expected %h", name, o_vec, prev_vec[use4]);
            else pass_cnt++;
        end
        while (!o_valid && lat < 40) begin
            @(posedge clk); lat++;
            @(negedge clk);
        end
        if (lat == 0) lat = 1;
        total_cnt++;
        if (lat !== exp_lat) $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
        else pass_cnt++;
        total_cnt++;
        if ({o_vec, o_g, o_r, o_s} !== {ev, eg, er, es})
            $display("FAIL %s result: got vec=%h grs=%b%b%b expected vec=%h grs=%b%b%b",
                     name, o_vec, o_g, o_r, o_s, ev, eg, er, es);
        else pass_cnt++;
        total_cnt++;
        if (o_ready !== 1'b0) $display("FAIL %s ready_in_done: got %b expected 0", name, o_ready);
        else pass_cnt++;
        // in_valid held high across the DONE->IDLE edge must not be accepted
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b0;
        total_cnt++;
        if ({o_valid, o_ready} !== 2'b01) $display("FAIL %s return_idle: got valid=%b ready=%b expected valid=0 ready=1", name, o_valid, o_ready);
        else pass_cnt++;
        total_cnt++;
        if (o_vec !== ev) $display("FAIL %s hold_in_idle: got %h expected %h", name, o_vec, ev);
        else pass_cnt++;
        prev_vec[use4] = ev;
    endtask

    task automatic test_reset();
        #2;
        total_cnt++;
        if ({rdy1, val1, vec1, g1, r1, s1} !== {1'b1, 1'b0, 8'h00, 3'b000})
            $display("FAIL reset_state: got ready=%b valid=%b vec=%h grs=%b%b%b expected ready=1 valid=0 vec=00 grs=000", rdy1, val1, vec1, g1, r1, s1);
        else pass_cnt++;
        total_cnt++;
        if ({rdy4, val4, vec4} !== {1'b1, 1'b0, 8'h00})
            $display("FAIL reset_state4: got ready=%b valid=%b vec=%h expected ready=1 valid=0 vec=00", rdy4, val4, vec4);
        else pass_cnt++;
        prev_vec[0] = 8'h00; prev_vec[1] = 8'h00;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_step1();
        do_op(1'b0, 8'hB4, 4'd0, 1, 8'hB4, 1'b0, 1'b0, 1'b0, "s1_sh0");
        do_op(1'b0, 8'hB4, 4'd3, 3, 8'h16, 1'b1, 1'b0, 1'b0, "s1_sh3");
        do_op(1'b0, 8'hB4, 4'd6, 6, 8'h02, 1'b1, 1'b1, 1'b1, "s1_sh6");
        do_op(1'b0, 8'h81, 4'd9, 9, 8'h00, 1'b0, 1'b1, 1'b1, "s1_sh9");
        do_op(1'b0, 8'hFF, 4'd8, 8, 8'h00, 1'b1, 1'b1, 1'b1, "s1_sh8");
    endtask

    task automatic test_clamp();
        do_op(1'b0, 8'hB4, 4'd15, 10, 8'h00, 1'b0, 1'b0, 1'b1, "clamp_b4");
        do_op(1'b0, 8'h00, 4'd15, 10, 8'h00, 1'b0, 1'b0, 1'b0, "clamp_zero");
        do_op(1'b0, 8'h01, 4'd10, 10, 8'h00, 1'b0, 1'b0, 1'b1, "exact_10");
    endtask

    task automatic test_step4();
        do_op(1'b1, 8'hB4, 4'd6, 2, 8'h02, 1'b1, 1'b1, 1'b1, "s4_sh6");
        do_op(1'b1, 8'hB4, 4'd15, 3, 8'h00, 1'b0, 1'b0, 1'b1, "s4_clamp");
        do_op(1'b1, 8'hB4, 4'd0, 1, 8'hB4, 1'b0, 1'b0, 1'b0, "s4_sh0");
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        @(negedge clk);
        sel = 1'b0; in_valid = 1'b1; in_vector = 8'hB4; in_shift = 4'd3;
        @(posedge clk); #1 in_valid = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!val1 && lat < 40) begin
            @(posedge clk); lat++;
            @(negedge clk);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid; in_vector = 8'h5A; in_shift = 4'd1;
            @(negedge clk);
            if ({val1, rdy1, vec1, g1, r1, s1} !== {1'b1, 1'b0, 8'h16, 3'b100}) bad++;
        end
        in_valid = 1'b0;
        total_cnt++;
        if (bad != 0) $display("FAIL bp_hold: got %0d unstable cycles expected 0", bad);
        else pass_cnt++;
        out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        total_cnt++;
        if ({val1, rdy1} !== 2'b01) $display("FAIL bp_release: got valid=%b ready=%b expected valid=0 ready=1", val1, rdy1);
        else pass_cnt++;
        prev_vec[0] = 8'h16;
    endtask

    task automatic test_reset_mid_shift();
        int seen;
        int lat;
        @(negedge clk);
        sel = 1'b0; in_valid = 1'b1; in_vector = 8'hB4; in_shift = 4'd6;
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({val1, rdy1, vec1, g1, r1, s1} !== {1'b0, 1'b1, 8'h00, 3'b000})
            $display("FAIL rst_mid_shift: got valid=%b ready=%b vec=%h grs=%b%b%b expected valid=0 ready=1 vec=00 grs=000", val1, rdy1, vec1, g1, r1, s1);
        else pass_cnt++;
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (val1) seen++;
        end
        total_cnt++;
        if (seen != 0) $display("FAIL rst_no_result: got %0d valid cycles expected 0", seen);
        else pass_cnt++;
        // first accept on the very first edge after reset release
        rst_n = 1'b0;
        in_valid = 1'b1; in_vector = 8'h3C; in_shift = 4'd2;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        total_cnt++;
        if (rdy1 !== 1'b0) $display("FAIL first_accept: got ready=%b expected 0", rdy1);
        else pass_cnt++;
        lat = 0;
        @(negedge clk);
        while (!val1 && lat < 40) begin
            @(posedge clk); lat++;
            @(negedge clk);
        end
        total_cnt++;
        if ({val1, vec1, g1, r1, s1} !== {1'b1, 8'h0F, 3'b000})
            $display("FAIL first_result: got valid=%b vec=%h grs=%b%b%b expected valid=1 vec=0f grs=000", val1, vec1, g1, r1, s1);
        else pass_cnt++;
        out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        prev_vec[0] = 8'h0F;
    endtask

    initial begin
        test_reset();
        test_step1();
        test_clamp();
        test_step4();
        test_backpressure();
        test_reset_mid_shift();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/denormalization_module.md
DENORMALIZATION_MODULE -- requirements
Module: denormalization_module

Interface
REQ-001 SHALL have parameter MANT_W, default 8, mantissa width in bits (>= 4).
REQ-002 SHALL have parameter STEP, default 1, maximum right-shift positions per cycle (1..MANT_W+2).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  request carries a valid operand.
REQ-006 SHALL have port in_ready  output  1  block can accept an operand.
REQ-007 SHALL have port in_vector  input  MANT_W  mantissa to denormalize.
REQ-008 SHALL have port in_shift  input  $clog2(MANT_W)+1  right-shift amount (exponent difference).
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port out_vector  output  MANT_W  right-shifted mantissa.
REQ-012 SHALL have ports out_guard, out_round, out_sticky  output  1 each  first, second, OR-of-remaining shifted-out bits.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, DONE; in_ready = (state==IDLE), out_valid = (state==DONE), both from registered state only.
REQ-014 SHALL accept an operand on a rising edge with in_valid=1 and in_ready=1; in_valid is ignored in SHIFT and DONE.
REQ-015 On accept SHALL load a MANT_W+2-bit working register {in_vector, guard=0, round=0}, clear sticky, set remaining = min(in_shift, MANT_W+2).
REQ-016 On accept SHALL go to DONE if remaining==0, else to SHIFT.
REQ-017 In SHIFT, each edge SHALL shift the working register right by k = min(STEP, remaining), OR all k bits leaving the LSB end into sticky, and decrement remaining by k.
REQ-018 SHALL move SHIFT->DONE on the edge where remaining reaches 0.
REQ-019 Latency accept-edge to out_valid SHALL be max(1, ceil(min(in_shift, MANT_W+2)/STEP)) rising edges.
REQ-020 Result SHALL equal a single combinational right shift of {in_vector,0,0} by min(in_shift, MANT_W+2), with sticky = OR of all bits shifted out, independent of STEP.
REQ-021 in_shift > MANT_W+2 SHALL be clamped: out_vector=0, guard=0, round=0, sticky = |in_vector.
REQ-022 In DONE, out_vector/out_guard/out_round/out_sticky SHALL hold stable while out_ready=0; on an edge with out_ready=1 SHALL return to IDLE.
REQ-023 No accept SHALL occur on the DONE->IDLE edge; in_ready first asserts the cycle after (max throughput one result per latency+1 cycles).
REQ-024 Result outputs SHALL hold their last value in IDLE and SHIFT; they change only on the edge entering DONE.

Reset
REQ-025 rst_n=0 SHALL immediately force state IDLE, out_valid=0, out_vector=0, guard=round=sticky=0, remaining=0, regardless of clk.
REQ-026 Reset asserted mid-SHIFT or in DONE SHALL discard the operation; no result is emitted after release.
REQ-027 First accept SHALL be possible on the first rising edge after rst_n deasserts.

Verification (MANT_W=8, STEP=1 unless stated)
REQ-028 in_vector=0xB4, in_shift=0 -> out_valid after 1 edge, out_vector=0xB4, g=0 r=0 s=0.
REQ-029 in_vector=0xB4, in_shift=3 -> out_valid after 3 edges, out_vector=0x16, g=1 r=0 s=0; in_shift=6 -> out_vector=0x02, g=1 r=1 s=1.
REQ-030 in_vector=0xB4, in_shift=15 -> clamped to 10, out_valid after 10 edges, out_vector=0x00, g=0 r=0 s=1; in_vector=0x00, in_shift=15 -> all zero.
REQ-031 STEP=4, in_vector=0xB4, in_shift=6 -> out_valid after 2 edges, same result as REQ-029.
REQ-032 out_ready held 0 for 5 cycles in DONE with in_valid=1 toggling -> outputs stable, in_ready=0, no new accept; out_ready=1 -> IDLE next edge.
REQ-033 rst_n pulsed low during SHIFT (in_shift=6, after 2 edges) -> out_valid=0, outputs zero, in_ready=1 immediately; no result after release.
